// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO: read pointers, RAM read port,
// fill/empty status and a first-word-fall-through output stream.
module async_fifo_rd_ctrl #(
    parameter int FIFO_DEPTH_BIT  = 5,
    parameter int DATA_WIDTH      = 8,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                      r_clk,
    input  logic                      r_rst,
    input  logic [FIFO_DEPTH_BIT:0]   write_addr_gray_sync,
    output logic [FIFO_DEPTH_BIT:0]   read_addr_gray,
    output logic                      mem_rd_en,
    output logic [FIFO_DEPTH_BIT-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]     mem_rd_data,
    output logic [DATA_WIDTH-1:0]     dout,
    output logic                      dout_valid,
    input  logic                      dout_ready,
    output logic                      empty,
    output logic                      almost_empty,
    output logic [FIFO_DEPTH_BIT:0]   rd_count,
    output logic                      ptr_err
);

    localparam int PW = FIFO_DEPTH_BIT + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {FIFO_DEPTH_BIT{1'b0}}};
    localparam logic [PW-1:0] AE_TH = PW'(ALMOST_EMPTY_TH);

    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] wbin;
    logic [PW-1:0] fill;
    logic [PW-1:0] rd_count_next;
    logic          fetch;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wbin = '0;
        for (int unsigned i = 0; i < PW; i++) begin
            wbin[i] = ^(write_addr_gray_sync >> i);
        end
    end

    always_comb begin
        fill          = wbin - rbin;
        fetch         = (fill != '0) && (!dout_valid || dout_ready);
        rbin_next     = fetch ? rbin + 1'b1 : rbin;
        rd_count_next = wbin - rbin_next;
    end

    assign mem_rd_en   = fetch && !r_rst;
    assign mem_rd_addr = rbin[FIFO_DEPTH_BIT-1:0];
    assign dout        = mem_rd_data;

    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            rbin           <= '0;
            read_addr_gray <= '0;
            dout_valid     <= 1'b0;
            rd_count       <= '0;
            empty          <= 1'b1;
            almost_empty   <= 1'b1;
            ptr_err        <= 1'b0;
        end else begin
            rbin           <= rbin_next;
            read_addr_gray <= rbin_next ^ (rbin_next >> 1);
            if (fetch) begin
                dout_valid <= 1'b1;
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
            end
            rd_count       <= rd_count_next;
            empty          <= (rd_count_next == '0);
            almost_empty   <= (rd_count_next <= AE_TH);
            // A full FIFO (fill == DEPTH) is legal; anything beyond is corruption.
            if (fill > DEPTH) begin
                ptr_err <= 1'b1;
            end
        end
    end

endmodule
